// File: rtl/prbs_checker.sv
// PRBS checker: hunts for the PRBS phase, verifies it, then flywheels
// on its own predictions while counting line errors per 32-bit window.
module prbs_checker #(
  parameter int N          = 8,
  parameter int VERIFY_LEN = 16,
  parameter int LOSS_ERRS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count,
  output logic        lost_lock
);

  localparam int GW = $clog2(VERIFY_LEN + 1);

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

  if (N != 8 && N != 17) begin : g_bad_n
    $error("prbs_checker: N must be 8 or 17");
  end

  state_t        state_q, state_d;
  logic [N:1]    w_q, w_d;
  logic [4:0]    fill_q, fill_d;
  logic [GW-1:0] good_q, good_d;
  logic [4:0]    wcnt_q, wcnt_d;
  logic [5:0]    werr_q, werr_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic [15:0]   ecnt_q, ecnt_d;
  logic          lost_q, lost_d;

  logic          p;
  logic          s;
  logic          mis;
  logic [5:0]    errs_n;

  if (N == 8) begin : g_tap8
    assign p = w_q[1] ^ w_q[3] ^ w_q[4] ^ w_q[5];
  end else begin : g_tap17
    assign p = w_q[1] ^ w_q[4];
  end

  assign mis    = in_bit ^ p;
  assign errs_n = werr_q + {5'd0, mis};
  // Once locked the window runs on predictions so line errors stay local
  assign s      = (state_q == LOCKED) ? p : in_bit;

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    fill_d  = fill_q;
    good_d  = good_q;
    wcnt_d  = wcnt_q;
    werr_d  = werr_q;
    err_d   = 1'b0;
    ecnt_d  = ecnt_q;
    lost_d  = lost_q;
    if (restart) begin
      state_d = HUNT;
      w_d     = '0;
      fill_d  = '0;
      good_d  = '0;
      wcnt_d  = '0;
      werr_d  = '0;
      ecnt_d  = '0;
      lost_d  = 1'b0;
    end else if (in_valid) begin
      w_d = {s, w_q[N:2]};
      unique case (state_q)
        HUNT: begin
          if (fill_q == 5'(N - 1)) begin
            state_d = VERIFY;
            fill_d  = '0;
            good_d  = '0;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        VERIFY: begin
          if (mis || (w_q == '0)) begin
            state_d = HUNT;
            fill_d  = '0;
            good_d  = '0;
          end else if (good_q == GW'(VERIFY_LEN - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
            wcnt_d  = '0;
            werr_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCKED: begin
          err_d  = mis;
          wcnt_d = wcnt_q + 5'd1;
          if (mis && (ecnt_q != 16'hFFFF))
            ecnt_d = ecnt_q + 16'd1;
          // The 32nd bit still belongs to the window it closes
          if (mis && (errs_n == 6'(LOSS_ERRS))) begin
            state_d = HUNT;
            lost_d  = 1'b1;
            fill_d  = '0;
            good_d  = '0;
            wcnt_d  = '0;
            werr_d  = '0;
          end else if (wcnt_q == 5'd31) begin
            werr_d = '0;
          end else begin
            werr_d = errs_n;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= HUNT;
      w_q      <= '0;
      fill_q   <= '0;
      good_q   <= '0;
      wcnt_q   <= '0;
      werr_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      ecnt_q   <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      fill_q   <= fill_d;
      good_q   <= good_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      ecnt_q   <= ecnt_d;
      lost_q   <= lost_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = ecnt_q;
  assign lost_lock = lost_q;

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL provide parameter N, default 8, meaning the LFSR length; only 8 and 17 are supported, and any other value SHALL cause an elaboration error.
REQ-002 SHALL provide parameter VERIFY_LEN, default 16, meaning the number of consecutive correct predictions required to lock.
REQ-003 SHALL provide parameter LOSS_ERRS, default 4, meaning the error count within a 32-bit window that causes loss of lock.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port restart, input, 1 bit: synchronous resynchronize and clear request, equivalent in role to load_seed on the generator.
REQ-007 SHALL have port in_valid, input, 1 bit: in_bit is accepted on a rising edge where in_valid=1.
REQ-008 SHALL have port in_bit, input, 1 bit: received serial bit, which is the generator output num[1].
REQ-009 SHALL have port locked, output, 1 bit: high while in the LOCKED state.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse for each mismatched bit while LOCKED.
REQ-011 SHALL have port err_count, output, 16 bits: saturating count of mismatches while LOCKED.
REQ-012 SHALL have port lost_lock, output, 1 bit: sticky flag, set when lock is lost.

Function
REQ-013 SHALL match the generator sequence b(t+N) = XOR of the tapped window bits, using 1-based window w[N:1], where w[1] is the oldest bit and w[N] is the newest.
REQ-014 SHALL use taps {1,3,4,5} for N=8 (x^8+x^4+x^3+x^2+1) and taps {1,4} for N=17 (x^17+x^3+1).
REQ-015 SHALL define the predicted bit p as the XOR of w at the tap positions, computed combinationally from the current window.
REQ-016 SHALL shift the window on each accepted bit: w <= {s, w[N:2]}, with s=in_bit in HUNT and VERIFY, and s=p in LOCKED (flywheel, so line errors do not propagate).
REQ-017 SHALL implement the FSM states HUNT, VERIFY and LOCKED, with HUNT as the reset state.
REQ-018 SHALL, in HUNT, increment fill_cnt on each accepted bit and move to VERIFY on the edge that accepts the N-th bit; the mismatch count is not evaluated in HUNT.
REQ-019 SHALL, in VERIFY, compare each accepted bit against p: on a match, increment good_cnt; on a mismatch, or when the window is all-zero before the shift, return to HUNT with fill_cnt=0 and good_cnt=0.
REQ-020 SHALL move from VERIFY to LOCKED on the edge accepting the VERIFY_LEN-th consecutive match, so locked=1 in the following cycle.
REQ-021 SHALL, in LOCKED, on a mismatching accepted bit: pulse err=1 for the next cycle, increment err_count (saturating at 16'hFFFF, no wrap) and increment win_errs.
REQ-022 SHALL, in LOCKED, count accepted bits with a 5-bit win_cnt running 0..31; when the 32nd bit is accepted, win_cnt wraps to 0 and win_errs clears, and the 32nd bit's own error counts in the window being closed.
REQ-023 SHALL, when win_errs reaches LOSS_ERRS in LOCKED, go to HUNT on that same edge and set lost_lock=1; the triggering bit still pulses err and increments err_count.
REQ-024 SHALL, on any entry to LOCKED, clear win_cnt and win_errs.
REQ-025 SHALL NOT clear err_count or lost_lock when lock is lost.
REQ-026 SHALL, on cycles with in_valid=0, hold all state and counters and drive err=0.
REQ-027 SHALL give restart=1 priority over in_valid: it clears the window to 0, the FSM to HUNT, all counters, err_count and lost_lock, and the bit presented on that edge is discarded.
REQ-028 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, while rst=0, immediately force: state=HUNT, w=0, fill_cnt=0, good_cnt=0, win_cnt=0, win_errs=0, locked=0, err=0, err_count=0, lost_lock=0.
REQ-030 SHALL, on reset assertion mid-lock, drop locked without waiting for a clock edge, and resume hunting on the first clock after rst returns high.

Verification
REQ-031 SHALL cover: N=8 generator seeded 8'hA5, in_valid=1 every cycle -> locked=1 in the cycle after the 24th accepted bit, err_count=0.
REQ-032 SHALL cover: N=8 locked, one bit flipped -> a single err pulse, err_count=1, locked stays 1, and later bits produce no further errors.
REQ-033 SHALL cover: N=8 locked, 4 flipped bits within one 32-bit window -> locked=0 after the 4th error, lost_lock=1, err_count=4, and relock 24 bits later.
REQ-034 SHALL cover: N=17 generator seeded 17'h1ACE5, with in_valid toggling 1,0,1,0 -> locked after 33 accepted bits, with no state change on idle cycles.
REQ-035 SHALL cover: a constant 0 input stream for 200 bits -> locked remains 0 and the FSM never leaves HUNT/VERIFY.
REQ-036 SHALL cover: rst=0 pulsed while locked with err_count=3 -> locked=0 and err_count=0 asynchronously; restart=1 while locked -> HUNT and lost_lock=0 on the next edge.
